// File: rtl/lcd_power_sequencer_if.sv
// Control/status bundle between the LCD power sequencer and its environment.
// The slave modport is the sequencer's view. The master modport is the view
// of the user controls and the timing generator.
interface lcd_power_sequencer_if;
    logic       Start;
    logic       Stop;
    logic       LCD_VSYNC;
    logic       Timing_En;
    logic       LCD_DISP;
    logic       LCD_BL_PWM;
    logic [1:0] Pattern_Sel;
    logic       Busy;
    logic [2:0] State;

    modport master (
        output Start,
        output Stop,
        output LCD_VSYNC,
        input  Timing_En,
        input  LCD_DISP,
        input  LCD_BL_PWM,
        input  Pattern_Sel,
        input  Busy,
        input  State
    );

    modport slave (
        input  Start,
        input  Stop,
        input  LCD_VSYNC,
        output Timing_En,
        output LCD_DISP,
        output LCD_BL_PWM,
        output Pattern_Sel,
        output Busy,
        output State
    );
endinterface

// File: rtl/lcd_power_sequencer.sv
// lcd_power_sequencer: frame-synchronous power-up/down sequencer for the
// 800x480 RGB LCD path. It releases the timing generator, raises DISP,
// brings the backlight up, cycles the test pattern every dwell period, and
// reverses the sequence on Stop. The rising edge of VSYNC is the frame tick.
//
// Optional feature macro LCD_BL_RAMP_EN:
//   defined   - the backlight ramps by BL_STEP per frame tick, saturating
//               at BL_MAX going up and at 0 going down.
//   undefined - the backlight jumps to BL_MAX (or to 0) on the first frame
//               tick of the ramp state, and BL_STEP has no effect.
module lcd_power_sequencer #(
    parameter logic [7:0] LEAD_FRAMES  = 8'd2,
    parameter logic [7:0] DWELL_FRAMES = 8'd60,
    parameter logic [2:0] NUM_PATTERNS = 3'd4,
    parameter logic [7:0] BL_STEP      = 8'd64,
    parameter logic [7:0] BL_MAX       = 8'd255
) (
    input  logic                 PixelClk,
    input  logic                 RST,
    lcd_power_sequencer_if.slave lcd
);

    // The encoding is visible on the State output and must not change.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TIM_WAIT  = 3'd1,
        S_DISP_WAIT = 3'd2,
        S_BL_UP     = 3'd3,
        S_RUN       = 3'd4,
        S_BL_DOWN   = 3'd5,
        S_DISP_OFF  = 3'd6,
        S_BAD       = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_vs_q;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] r_duty;
    logic [7:0] w_duty_nxt;
    logic       r_timing_en;
    logic       w_timing_en_nxt;
    logic       r_disp;
    logic       w_disp_nxt;
    logic [1:0] r_pat;
    logic [1:0] w_pat_nxt;
    logic       r_busy;
    logic [7:0] r_pwm_cnt;
    logic       r_pwm;

    logic       w_tick;
    logic [7:0] w_cnt_inc;
    logic       w_lead_done;
    logic       w_dwell_done;
    logic [7:0] w_duty_up;
    logic [7:0] w_duty_dn;
    logic       w_pat_last;
    logic [1:0] w_pat_inc;

`ifdef LCD_BL_RAMP_EN
    // The 9-bit sum means a step past 255 still clamps to BL_MAX and does
    // not wrap to a small value.
    function automatic logic [7:0] f_sat_up(input logic [7:0] duty);
        logic [8:0] sum;
        sum = {1'b0, duty} + {1'b0, BL_STEP};
        return (sum >= {1'b0, BL_MAX}) ? BL_MAX : sum[7:0];
    endfunction

    // Clamps at zero, so the ramp always ends on exactly 0.
    function automatic logic [7:0] f_sat_down(input logic [7:0] duty);
        return (duty > BL_STEP) ? (duty - BL_STEP) : 8'd0;
    endfunction

    assign w_duty_up = f_sat_up(r_duty);
    assign w_duty_dn = f_sat_down(r_duty);
`else
    assign w_duty_up = BL_MAX;
    assign w_duty_dn = 8'd0;
`endif

    // A frame tick is a VSYNC rising edge. r_vs_q resets high, so VSYNC
    // already high at reset release is not counted.
    assign w_tick       = lcd.LCD_VSYNC & ~r_vs_q;
    assign w_cnt_inc    = r_cnt + 8'd1;
    assign w_lead_done  = (w_cnt_inc == LEAD_FRAMES);
    assign w_dwell_done = (w_cnt_inc == DWELL_FRAMES);
    assign w_pat_last   = ({1'b0, r_pat} == (NUM_PATTERNS - 3'd1));
    assign w_pat_inc    = w_pat_last ? 2'd0 : (r_pat + 2'd1);

    // Next-state and next-output logic. When Stop arrives on a tick edge,
    // Stop wins and the tick is dropped.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_duty_nxt      = r_duty;
        w_timing_en_nxt = r_timing_en;
        w_disp_nxt      = r_disp;
        w_pat_nxt       = r_pat;

        case (r_state)
            S_IDLE: begin
                if (lcd.Start && !lcd.Stop) begin
                    w_state_nxt     = S_TIM_WAIT;
                    w_timing_en_nxt = 1'b1;
                    w_cnt_nxt       = 8'd0;
                end
            end

            S_TIM_WAIT: begin
                if (lcd.Stop) begin
                    w_state_nxt = S_DISP_OFF;
                    w_disp_nxt  = 1'b0;
                    w_cnt_nxt   = 8'd0;
                end else if (w_tick) begin
                    if (w_lead_done) begin
                        w_state_nxt = S_DISP_WAIT;
                        w_disp_nxt  = 1'b1;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end

            S_DISP_WAIT: begin
                if (lcd.Stop) begin
                    w_state_nxt = S_DISP_OFF;
                    w_disp_nxt  = 1'b0;
                    w_cnt_nxt   = 8'd0;
                end else if (w_tick) begin
                    if (w_lead_done) begin
                        w_state_nxt = S_BL_UP;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end

            S_BL_UP: begin
                if (lcd.Stop) begin
                    w_state_nxt = S_BL_DOWN;
                end else if (w_tick) begin
                    w_duty_nxt = w_duty_up;
                    if (w_duty_up == BL_MAX) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = 8'd0;
                    end
                end
            end

            S_RUN: begin
                if (lcd.Stop) begin
                    w_state_nxt = S_BL_DOWN;
                end else if (w_tick) begin
                    if (w_dwell_done) begin
                        w_pat_nxt = w_pat_inc;
                        w_cnt_nxt = 8'd0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end

            S_BL_DOWN: begin
                if (w_tick) begin
                    w_duty_nxt = w_duty_dn;
                    if (w_duty_dn == 8'd0) begin
                        w_state_nxt = S_DISP_OFF;
                        w_disp_nxt  = 1'b0;
                        w_cnt_nxt   = 8'd0;
                    end
                end
            end

            S_DISP_OFF: begin
                if (w_tick) begin
                    if (w_lead_done) begin
                        w_state_nxt     = S_IDLE;
                        w_timing_en_nxt = 1'b0;
                        w_pat_nxt       = 2'd0;
                        w_cnt_nxt       = 8'd0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end

            default: begin
                // Code 7 is unreachable. If it ever appears, return to IDLE
                // with everything switched off.
                w_state_nxt     = S_IDLE;
                w_cnt_nxt       = 8'd0;
                w_duty_nxt      = 8'd0;
                w_timing_en_nxt = 1'b0;
                w_disp_nxt      = 1'b0;
                w_pat_nxt       = 2'd0;
            end
        endcase
    end

    // State register and registered sequencing outputs. Busy is taken from
    // the next state so that it changes on the same edge as State.
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_duty      <= 8'd0;
            r_timing_en <= 1'b0;
            r_disp      <= 1'b0;
            r_pat       <= 2'd0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_duty      <= w_duty_nxt;
            r_timing_en <= w_timing_en_nxt;
            r_disp      <= w_disp_nxt;
            r_pat       <= w_pat_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    // VSYNC history for the frame-tick edge detector.
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            r_vs_q <= 1'b1;
        end else begin
            r_vs_q <= lcd.LCD_VSYNC;
        end
    end

    // Free-running 8-bit PWM. Duty 255 is forced fully on, because the
    // compare alone would leave the output low for one count in 256.
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            r_pwm_cnt <= 8'd0;
            r_pwm     <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            r_pwm     <= (r_duty == 8'hFF) | (r_pwm_cnt < r_duty);
        end
    end

    assign lcd.State       = r_state;
    assign lcd.Busy        = r_busy;
    assign lcd.Timing_En   = r_timing_en;
    assign lcd.LCD_DISP    = r_disp;
    assign lcd.LCD_BL_PWM  = r_pwm;
    assign lcd.Pattern_Sel = r_pat;

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// Testbench for lcd_power_sequencer. A frame-level behavioural model is
// checked against the DUT on every cycle. Directed scenarios pin the model
// to hand-computed values. A randomized phase then mixes VSYNC, Start,
// Stop and reset pulses.
`timescale 1ns/1ps
module tb_lcd_power_sequencer;

    localparam int LEAD  = 2;
    localparam int DWELL = 3;
    localparam int NPAT  = 4;
    localparam int STEP  = 64;
    localparam int BMAX  = 255;

`ifdef LCD_BL_RAMP_EN
    localparam int UP_TICKS_A = 2;   // BL_UP ticks before the PWM duty count
    localparam int UP_TICKS_B = 2;   // remaining BL_UP ticks to reach RUN
    localparam int PWM_HI     = 128;
    localparam int DOWN_TICKS = 4;
`else
    localparam int UP_TICKS_A = 1;
    localparam int UP_TICKS_B = 0;
    localparam int PWM_HI     = 256;
    localparam int DOWN_TICKS = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    lcd_power_sequencer_if bus();

    lcd_power_sequencer #(
        .LEAD_FRAMES (8'd2),
        .DWELL_FRAMES(8'd3),
        .NUM_PATTERNS(3'd4),
        .BL_STEP     (8'd64),
        .BL_MAX      (8'd255)
    ) dut (
        .PixelClk(clk),
        .RST     (rst),
        .lcd     (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: the phase number uses the published State codes. Duty is
    // the backlight level, and cnt counts frame ticks in the current phase.
    int m_st, m_cnt, m_duty, m_ten, m_disp, m_pat, m_pwm, m_pcnt, m_vsq;

    always @(posedge clk or posedge rst) begin : model
        int  st, cnt, duty, ten, disp, pat;
        bit  tick, go, halt;
        if (rst) begin
            m_st <= 0; m_cnt <= 0; m_duty <= 0; m_ten <= 0; m_disp <= 0;
            m_pat <= 0; m_pwm <= 0; m_pcnt <= 0; m_vsq <= 1;
        end else begin
            st = m_st; cnt = m_cnt; duty = m_duty; ten = m_ten; disp = m_disp; pat = m_pat;
            tick = bus.LCD_VSYNC && !m_vsq[0];
            go   = bus.Start;
            halt = bus.Stop;
            m_pwm  <= ((m_duty == 255) || (m_pcnt < m_duty)) ? 1 : 0;
            m_pcnt <= (m_pcnt + 1) % 256;
            m_vsq  <= bus.LCD_VSYNC ? 1 : 0;
            if (st == 0) begin
                if (go && !halt) begin st = 1; ten = 1; cnt = 0; end
            end else if (st == 1 || st == 2) begin
                if (halt) begin st = 6; disp = 0; cnt = 0; end
                else if (tick) begin
                    cnt++;
                    if (cnt == LEAD) begin
                        if (st == 1) disp = 1;
                        st = st + 1; cnt = 0;
                    end
                end
            end else if (st == 3) begin
                if (halt) st = 5;
                else if (tick) begin
`ifdef LCD_BL_RAMP_EN
                    duty = (duty + STEP > BMAX) ? BMAX : duty + STEP;
`else
                    duty = BMAX;
`endif
                    if (duty == BMAX) begin st = 4; cnt = 0; end
                end
            end else if (st == 4) begin
                if (halt) st = 5;
                else if (tick) begin
                    cnt++;
                    if (cnt == DWELL) begin pat = (pat + 1) % NPAT; cnt = 0; end
                end
            end else if (st == 5) begin
                if (tick) begin
`ifdef LCD_BL_RAMP_EN
                    duty = (duty - STEP < 0) ? 0 : duty - STEP;
`else
                    duty = 0;
`endif
                    if (duty == 0) begin st = 6; disp = 0; cnt = 0; end
                end
            end else begin
                if (tick) begin
                    cnt++;
                    if (cnt == LEAD) begin st = 0; ten = 0; pat = 0; cnt = 0; end
                end
            end
            m_st <= st; m_cnt <= cnt; m_duty <= duty; m_ten <= ten; m_disp <= disp; m_pat <= pat;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("State",       32'(bus.State),       m_st);
        check("Busy",        32'(bus.Busy),        (m_st != 0) ? 1 : 0);
        check("Timing_En",   32'(bus.Timing_En),   m_ten);
        check("LCD_DISP",    32'(bus.LCD_DISP),    m_disp);
        check("LCD_BL_PWM",  32'(bus.LCD_BL_PWM),  m_pwm);
        check("Pattern_Sel", 32'(bus.Pattern_Sel), m_pat);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One frame: VSYNC rises, then falls, then there are two quiet cycles.
    task automatic ticks(input int n);
        repeat (n) begin
            bus.LCD_VSYNC = 1'b1;
            @(negedge clk);
            bus.LCD_VSYNC = 1'b0;
            cyc(2);
        end
    endtask

    task automatic pulse_start();
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.Stop = 1'b1;
        @(negedge clk);
        bus.Stop = 1'b0;
    endtask

    initial begin
        int hi;
        bus.Start = 1'b0;
        bus.Stop = 1'b0;
        bus.LCD_VSYNC = 1'b0;
        rst = 1'b1;
        cyc(3);
        check("rst_state", 32'(bus.State), 0);
        check("rst_busy",  32'(bus.Busy), 0);
        check("rst_ten",   32'(bus.Timing_En), 0);
        check("rst_pwm",   32'(bus.LCD_BL_PWM), 0);
        rst = 1'b0;
        cyc(2);

        // Power-up sequence.
        pulse_start();
        check("start_ten",   32'(bus.Timing_En), 1);
        check("start_state", 32'(bus.State), 1);
        ticks(1);
        check("t1_disp", 32'(bus.LCD_DISP), 0);
        ticks(1);
        check("t2_disp",  32'(bus.LCD_DISP), 1);
        check("t2_state", 32'(bus.State), 2);
        ticks(2);
        check("t4_state", 32'(bus.State), 3);
        ticks(UP_TICKS_A);
        cyc(1);
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            hi += int'(bus.LCD_BL_PWM);
        end
        check("pwm_high_count", 32'(hi), PWM_HI);
        ticks(UP_TICKS_B);
        check("run_state", 32'(bus.State), 4);

        // Pattern cycling in RUN.
        for (int i = 1; i <= 12; i++) begin
            ticks(1);
            if (i % 3 == 0) check("run_pat", 32'(bus.Pattern_Sel), (i / 3) % 4);
        end
        ticks(3);
        check("run_pat13", 32'(bus.Pattern_Sel), 1);

        // Power-down sequence.
        pulse_stop();
        check("stop_state", 32'(bus.State), 5);
        ticks(DOWN_TICKS - 1);
        check("down_disp_still_on", 32'(bus.LCD_DISP), 1);
        ticks(1);
        check("down_disp_off", 32'(bus.LCD_DISP), 0);
        check("down_state",    32'(bus.State), 6);
        ticks(1);
        check("off1_state", 32'(bus.State), 6);
        check("off1_ten",   32'(bus.Timing_En), 1);
        ticks(1);
        check("idle_state", 32'(bus.State), 0);
        check("idle_ten",   32'(bus.Timing_En), 0);
        check("idle_pat",   32'(bus.Pattern_Sel), 0);

        // Start and Stop together while IDLE.
        bus.Start = 1'b1;
        bus.Stop = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.Stop = 1'b0;
        check("startstop_state", 32'(bus.State), 0);

        // Stop during TIM_WAIT.
        pulse_start();
        ticks(1);
        pulse_stop();
        check("timstop_state", 32'(bus.State), 6);
        ticks(1);
        check("timstop_t1", 32'(bus.State), 6);
        ticks(1);
        check("timstop_t2", 32'(bus.State), 0);

        // Asynchronous reset in RUN.
        pulse_start();
        ticks(2 * LEAD + UP_TICKS_A + UP_TICKS_B + 3);
        check("pre_rst_pat", 32'(bus.Pattern_Sel), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_state", 32'(bus.State), 0);
        check("arst_disp",  32'(bus.LCD_DISP), 0);
        check("arst_ten",   32'(bus.Timing_En), 0);
        check("arst_pwm",   32'(bus.LCD_BL_PWM), 0);
        check("arst_pat",   32'(bus.Pattern_Sel), 0);
        bus.LCD_VSYNC = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        pulse_start();
        cyc(3);
        bus.LCD_VSYNC = 1'b0;
        cyc(2);
        ticks(1);
        check("rel_high_t1_disp", 32'(bus.LCD_DISP), 0);
        ticks(1);
        check("rel_high_t2_disp", 32'(bus.LCD_DISP), 1);

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            bus.LCD_VSYNC = ($urandom_range(0, 3) == 0);
            bus.Start = ($urandom_range(0, 29) == 0);
            bus.Stop = ($urandom_range(0, 89) == 0);
            rst = ($urandom_range(0, 1499) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        bus.Start = 1'b0;
        bus.Stop = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
